// File: rtl/pwm_multi_burst.sv
// NCH-channel PWM generator: shared period counter, per-channel duty/polarity,
// double-buffered config applied at period wraps, optional burst gating.
//
// state | meaning
// IDLE  | counter held at 0, outputs parked at their inversion level
// ON    | counter running, channels pulse against their duty
// GAP   | counter running, outputs parked, counting idle burst periods
module pwm_multi_burst #(
    parameter int NCH = 4,
    parameter int CW  = 16,
    parameter int BW  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              cfg_load,
    input  logic [CW-1:0]     cfg_period,
    input  logic [NCH*CW-1:0] cfg_duty,
    input  logic [NCH-1:0]    cfg_inv,
    input  logic              cfg_burst,
    input  logic [BW-1:0]     cfg_blen,
    input  logic [BW-1:0]     cfg_bgap,
    output logic [NCH-1:0]    pwm_out,
    output logic              period_tick,
    output logic              burst_gap,
    output logic              cfg_pending
);

    typedef enum logic [1:0] {IDLE = 2'd0, ON = 2'd1, GAP = 2'd2} stateT;

    typedef struct packed {
        logic [CW-1:0]     period;
        logic [NCH*CW-1:0] duty;
        logic [NCH-1:0]    inv;
        logic              burst;
        logic [BW-1:0]     blen;
        logic [BW-1:0]     bgap;
    } cfgT;

    stateT         state;
    cfgT           portCfg;
    cfgT           shadowCfg;
    cfgT           activeCfg;
    cfgT           nextCfg;
    logic [CW-1:0] cnt;
    logic [BW-1:0] bcnt;
    logic          periodOk;
    logic          wrap;
    logic          noActive;
    logic [NCH-1:0] raw;

    always_comb begin
        portCfg  = {cfg_period, cfg_duty, cfg_inv, cfg_burst, cfg_blen, cfg_bgap};
        periodOk = (activeCfg.period >= CW'(2));
        wrap     = (state != IDLE) && periodOk && (cnt == activeCfg.period - CW'(1));
        // A burst with zero active periods never lets the channels pulse.
        noActive = activeCfg.burst && (activeCfg.blen == '0) && (activeCfg.bgap != '0);
        // Config that will be active after this cycle's wrap; wrap decisions use it.
        nextCfg = activeCfg;
        if (cfg_load) begin
            nextCfg = portCfg;
        end else if (cfg_pending) begin
            nextCfg = shadowCfg;
        end
        raw = '0;
        for (int i = 0; i < NCH; i++) begin
            raw[i] = (state == ON) && periodOk && !noActive &&
                     (cnt < activeCfg.duty[i*CW +: CW]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            bcnt        <= '0;
            shadowCfg   <= '0;
            activeCfg   <= '0;
            cfg_pending <= 1'b0;
            pwm_out     <= '0;
            period_tick <= 1'b0;
            burst_gap   <= 1'b0;
        end else begin
            if (state == IDLE) begin
                if (cfg_pending) begin
                    activeCfg <= shadowCfg;
                end
                if (cfg_load) begin
                    shadowCfg   <= portCfg;
                    cfg_pending <= 1'b1;
                end else begin
                    cfg_pending <= 1'b0;
                end
            end else if (wrap) begin
                activeCfg   <= nextCfg;
                cfg_pending <= 1'b0;
            end else if (cfg_load) begin
                shadowCfg   <= portCfg;
                cfg_pending <= 1'b1;
            end

            period_tick <= wrap;
            pwm_out     <= raw ^ activeCfg.inv;

            case (state)
                IDLE: begin
                    cnt       <= '0;
                    bcnt      <= '0;
                    burst_gap <= 1'b0;
                    if (en && periodOk) begin
                        state <= ON;
                    end
                end
                ON, GAP: begin
                    if (!en || !periodOk) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        bcnt      <= '0;
                        burst_gap <= 1'b0;
                    end else begin
                        cnt <= wrap ? '0 : cnt + CW'(1);
                        if (wrap && state == ON) begin
                            if (nextCfg.burst && nextCfg.bgap != '0 &&
                                (nextCfg.blen == '0 || bcnt == nextCfg.blen - BW'(1))) begin
                                state     <= GAP;
                                bcnt      <= '0;
                                burst_gap <= 1'b1;
                            end else if (nextCfg.burst && nextCfg.bgap != '0) begin
                                bcnt <= bcnt + BW'(1);
                            end else begin
                                bcnt <= '0;
                            end
                        end else if (wrap) begin
                            if (!nextCfg.burst || nextCfg.bgap == '0 ||
                                bcnt == nextCfg.bgap - BW'(1)) begin
                                state     <= ON;
                                bcnt      <= '0;
                                burst_gap <= 1'b0;
                            end else begin
                                bcnt <= bcnt + BW'(1);
                            end
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    bcnt      <= '0;
                    burst_gap <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_multi_burst.sv
// Directed bench for pwm_multi_burst: duty patterns, deferred reload, inversion,
// burst gating, reset mid-gap and reload on the wrap cycle.
module tb_pwm_multi_burst;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        cfg_load;
    logic [15:0] cfg_period;
    logic [63:0] cfg_duty;
    logic [3:0]  cfg_inv;
    logic        cfg_burst;
    logic [7:0]  cfg_blen;
    logic [7:0]  cfg_bgap;
    logic [3:0]  pwm_out;
    logic        period_tick;
    logic        burst_gap;
    logic        cfg_pending;

    int nCompared   = 0;
    int nMismatched = 0;

    pwm_multi_burst #(.NCH(4), .CW(16), .BW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .cfg_load   (cfg_load),
        .cfg_period (cfg_period),
        .cfg_duty   (cfg_duty),
        .cfg_inv    (cfg_inv),
        .cfg_burst  (cfg_burst),
        .cfg_blen   (cfg_blen),
        .cfg_bgap   (cfg_bgap),
        .pwm_out    (pwm_out),
        .period_tick(period_tick),
        .burst_gap  (burst_gap),
        .cfg_pending(cfg_pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic loadCfg(input logic [15:0] p, input logic [15:0] d0, input logic [15:0] d1,
                           input logic [15:0] d2, input logic [15:0] d3, input logic [3:0] inv,
                           input logic b, input logic [7:0] bl, input logic [7:0] bg);
        cfg_period = p;
        cfg_duty   = {d3, d2, d1, d0};
        cfg_inv    = inv;
        cfg_burst  = b;
        cfg_blen   = bl;
        cfg_bgap   = bg;
        cfg_load   = 1'b1;
        tick();
        cfg_load   = 1'b0;
    endtask

    task automatic waitTick(input string tag);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (period_tick) break;
        end
        chk(tag, period_tick, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] expPwm;
        int phase;
        int nphase;

        rst = 1'b1; en = 1'b0; cfg_load = 1'b0;
        cfg_period = '0; cfg_duty = '0; cfg_inv = '0;
        cfg_burst = 1'b0; cfg_blen = '0; cfg_bgap = '0;
        repeat (3) tick();
        chk("rst_pwm", pwm_out, 0);
        chk("rst_tick", period_tick, 0);
        chk("rst_gap", burst_gap, 0);
        chk("rst_pend", cfg_pending, 0);
        rst = 1'b0;

        // 1: four duty cases in one period of 10
        en = 1'b1;
        loadCfg(16'd10, 16'd3, 16'd0, 16'd10, 16'd5, 4'b0000, 1'b0, 8'd0, 8'd0);
        chk("t1_pend_idle", cfg_pending, 1);
        waitTick("t1_align");
        for (int k = 0; k < 10; k++) begin
            tick();
            expPwm = {k < 5, 1'b1, 1'b0, k < 3};
            chk($sformatf("t1_pwm_%0d", k), pwm_out, expPwm);
            chk($sformatf("t1_tick_%0d", k), period_tick, k == 9);
        end

        // 2: reload D0 mid-period, applied at the wrap
        repeat (4) tick();
        loadCfg(16'd10, 16'd7, 16'd0, 16'd10, 16'd5, 4'b0000, 1'b0, 8'd0, 8'd0);
        chk("t2_pend_set", cfg_pending, 1);
        tick();
        chk("t2_pwm_cnt5", pwm_out, 4'b0100);
        chk("t2_pend_hold", cfg_pending, 1);
        repeat (4) tick();
        chk("t2_wrap_tick", period_tick, 1);
        chk("t2_pend_clr", cfg_pending, 0);
        for (int k = 0; k < 10; k++) begin
            tick();
            expPwm = {k < 5, 1'b1, 1'b0, k < 7};
            chk($sformatf("t2_pwm_%0d", k), pwm_out, expPwm);
        end

        // 4: inversion while disabled, then ch0 low for D0 cycles
        en = 1'b0;
        repeat (2) tick();
        loadCfg(16'd10, 16'd3, 16'd0, 16'd0, 16'd0, 4'b0001, 1'b0, 8'd0, 8'd0);
        repeat (3) tick();
        chk("t4_idle_inv", pwm_out, 4'b0001);
        chk("t4_idle_gap", burst_gap, 0);
        en = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("t4_pwm_%0d", k), pwm_out, (k < 3) ? 4'b0000 : 4'b0001);
        end

        // 3: burst of 2 periods on, 3 periods gap, P=8, D0=4
        en = 1'b0;
        repeat (2) tick();
        loadCfg(16'd8, 16'd4, 16'd0, 16'd0, 16'd0, 4'b0000, 1'b1, 8'd2, 8'd3);
        repeat (2) tick();
        chk("t3_pre_gap", burst_gap, 0);
        en = 1'b1;
        tick();
        for (int c = 0; c < 80; c++) begin
            tick();
            phase  = (c / 8) % 5;
            nphase = ((c + 1) / 8) % 5;
            chk($sformatf("t3_pwm_%0d", c), pwm_out, (phase < 2 && (c % 8) < 4) ? 4'b0001 : 4'b0000);
            chk($sformatf("t3_tick_%0d", c), period_tick, (c % 8) == 7);
            chk($sformatf("t3_gap_%0d", c), burst_gap, nphase >= 2);
        end

        // 5: reset in the gap at cnt=5
        repeat (21) tick();
        chk("t5_in_gap", burst_gap, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rst_pwm", pwm_out, 0);
        chk("t5_rst_tick", period_tick, 0);
        chk("t5_rst_gap", burst_gap, 0);
        chk("t5_rst_pend", cfg_pending, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("t5_post_pwm_%0d", k), pwm_out, 0);
            chk($sformatf("t5_post_gap_%0d", k), burst_gap, 0);
        end

        // 6: reload on the wrap cycle goes straight to active, then P=1 parks in IDLE
        loadCfg(16'd10, 16'd3, 16'd0, 16'd10, 16'd5, 4'b0000, 1'b0, 8'd0, 8'd0);
        waitTick("t6_align");
        repeat (9) tick();
        loadCfg(16'd6, 16'd3, 16'd0, 16'd10, 16'd5, 4'b0000, 1'b0, 8'd0, 8'd0);
        chk("t6_wrap_tick", period_tick, 1);
        chk("t6_wrap_pend", cfg_pending, 0);
        for (int k = 0; k < 6; k++) begin
            tick();
            expPwm = {k < 5, 1'b1, 1'b0, k < 3};
            chk($sformatf("t6_pwm_%0d", k), pwm_out, expPwm);
            chk($sformatf("t6_tick_%0d", k), period_tick, k == 5);
            chk($sformatf("t6_pend_%0d", k), cfg_pending, 0);
        end
        loadCfg(16'd1, 16'd3, 16'd0, 16'd10, 16'd5, 4'b1010, 1'b0, 8'd0, 8'd0);
        chk("t6_p1_pend", cfg_pending, 1);
        repeat (8) tick();
        chk("t6_p1_pwm", pwm_out, 4'b1010);
        chk("t6_p1_pend_clr", cfg_pending, 0);
        chk("t6_p1_gap", burst_gap, 0);
        tick();
        chk("t6_p1_tick", period_tick, 0);
        chk("t6_p1_pwm_hold", pwm_out, 4'b1010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
